vector_lane_fu: RTL and testbench
=================================

Name: vector_lane_fu

Overview:
- One functional lane of the vector datapath. It sits directly downstream of the instruction execution unit; one instance per lane, NUM_OF_LANES instances in total.
- Accepts a single element operation (operand pair, destination vector register, element index, opcode) and computes the result in a small multi-cycle datapath.
- Writes the result back to the vector register file through a request/grant port.
- Reports busy, which the execution unit uses to pick the next free lane.

Parameters:
- VECTOR_REG_WIDTH, 64, operand and result width in bits.
- NUM_OF_VECTOR_REG, 8, number of vector registers; sets the width of vec_reg_in.
- ADDR_FIELD_WIDTH, 6, width of the element index within a vector register.
- MUL_LATENCY, 2, execute cycles for SMUL (minimum 1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- vld  input  1  operation valid; sampled only while busy=0.
- data0  input  VECTOR_REG_WIDTH  operand A.
- data1  input  VECTOR_REG_WIDTH  operand B.
- vec_reg_in  input  $clog2(NUM_OF_VECTOR_REG)  destination vector register.
- vec_addr  input  ADDR_FIELD_WIDTH  destination element index.
- functional_opcode  input  function_opcode_t  one of SADD, SSUB, SMUL, SDIV.
- busy  output  1  lane occupied.
- wr_req_vld  output  1  writeback request.
- wr_req_reg  output  $clog2(NUM_OF_VECTOR_REG)  writeback register.
- wr_req_addr  output  ADDR_FIELD_WIDTH  writeback element index.
- wr_req_data  output  VECTOR_REG_WIDTH  result.
- wr_req_grant  input  1  register file accepted the writeback this cycle.
- div_by_zero  output  1  one-cycle pulse: SDIV with data1=0 was accepted.

Behaviour:
Reset:
- Asserting reset at any time, including mid-operation, forces state IDLE.
- busy=0, wr_req_vld=0, wr_req_reg=0, wr_req_addr=0, wr_req_data=0, div_by_zero=0.
- The in-flight operation is discarded and no writeback occurs.

Acceptance:
- An operation is accepted at edge T when state=IDLE and vld=1.
- On accept, the lane latches data0, data1, vec_reg_in, vec_addr and functional_opcode.
- busy=1 from T+1 until the cycle after a grant.
- vld while busy=1 is ignored. The upstream unit must drop vld, or present a new operation, once busy is seen.
- Unencoded opcode values are treated as SADD.

States and transitions:
- IDLE: on accept with SADD/SSUB, go to WB. With SMUL, go to MUL. With SDIV, go to DIV.
- MUL: down-counter loaded with MUL_LATENCY-1. Go to WB when the counter reaches 0.
- DIV: restoring unsigned division, one quotient bit per cycle, 6-bit iteration counter. Go to WB after VECTOR_REG_WIDTH cycles.
- WB: wr_req_vld=1 with all wr_req_* fields stable. On wr_req_grant=1, go to IDLE. busy and wr_req_vld are 0 in the next cycle.

Latency (wr_req_vld first high):
- SADD/SSUB: T+1.
- SMUL: T+1+MUL_LATENCY.
- SDIV: T+1+VECTOR_REG_WIDTH.
- Each case then holds high until the grant.

Back-to-back operation:
- A grant at edge G returns the lane to IDLE with busy=0 after G.
- A new operation can be accepted at edge G+1, so the minimum issue interval is grant+1.
- The lane does not accept a new operation in the same edge as a grant.

Arithmetic (all VECTOR_REG_WIDTH bits, two's complement):
- SADD: data0+data1, wrapping modulo 2^W.
- SSUB: data0-data1, wrapping.
- SMUL: low W bits of the product.
- SDIV: unsigned quotient data0/data1.
- Divide by zero: quotient is all ones. The lane still runs the full DIV duration, and div_by_zero pulses at T+1.

Other rules:
- A grant while wr_req_vld=0 is ignored.
- Simultaneous reset and grant: reset wins.

Decomposition:
- Shared package: function_opcode_t (SADD=0, SSUB=1, SMUL=2, SDIV=3), VECTOR_REG_WIDTH, NUM_OF_VECTOR_REG, ADDR_FIELD_WIDTH and a lane state enum.
- These are placed alongside the existing vopcode_t and cntrl_req_t, so the execution unit and the lane share one definition.
- One natural sub-module: lane_divider, the iterative restoring divider with start/done. It is reusable for future DIVVSD/DIVSVD support.

Test Plan:
- Reset checks:
  - Reset with wr_req_vld pending -> all outputs return to 0 the same cycle, with no writeback.
  - SDIV started, reset at iteration 30, then SADD 1+1 -> result 2 with SADD latency.
- SADD: data0=5, data1=7, reg=3, addr=10; grant held 1 -> wr_req_vld at T+1 with data=12, reg=3, addr=10; busy low at T+2.
- SSUB: data0=0, data1=1 -> wr_req_data=0xFFFF_FFFF_FFFF_FFFF (wraparound).
- SMUL: data0=0x1_0000_0000, data1=0x1_0000_0003; grant withheld 5 cycles -> data=0x3_0000_0000 appears at T+3 and stays stable until grant; busy high throughout.
- SDIV:
  - 100/7 -> data=14 at T+65.
  - 9/0 -> div_by_zero pulse at T+1 and data=all ones at T+65.
- Back-to-back: SADD issued with vld held high across the grant -> second accept exactly one cycle after busy falls; no vld captured while busy.

Source files
------------

// File: rtl/vector_lane_fu_pkg.sv
// Shared vector-lane definitions: opcodes, widths and lane FSM encoding.
// Used by both the execution unit and the lanes.
package vector_lane_fu_pkg;

  localparam int unsigned VECTOR_REG_WIDTH  = 64;
  localparam int unsigned NUM_OF_VECTOR_REG = 8;
  localparam int unsigned ADDR_FIELD_WIDTH  = 6;
  localparam int unsigned MUL_LATENCY       = 2;
  localparam int unsigned VEC_REG_IDX_WIDTH = $clog2(NUM_OF_VECTOR_REG);

  typedef enum logic [1:0] {
    SADD = 2'd0,
    SSUB = 2'd1,
    SMUL = 2'd2,
    SDIV = 2'd3
  } function_opcode_t;

  // Lane FSM encoding, kept as plain constants for legacy netlist compatibility.
  typedef logic [1:0] lane_state_t;
  localparam lane_state_t ST_IDLE = 2'd0;
  localparam lane_state_t ST_MUL  = 2'd1;
  localparam lane_state_t ST_DIV  = 2'd2;
  localparam lane_state_t ST_WB   = 2'd3;

  typedef enum logic [3:0] {
    VOP_NOP    = 4'd0,
    VOP_VADDVV = 4'd1,
    VOP_VSUBVV = 4'd2,
    VOP_VMULVV = 4'd3,
    VOP_VDIVVV = 4'd4,
    VOP_VLOAD  = 4'd5,
    VOP_VSTORE = 4'd6
  } vopcode_t;

  typedef struct packed {
    logic                         vld;
    vopcode_t                     vopcode;
    logic [VEC_REG_IDX_WIDTH-1:0] vd;
    logic [VEC_REG_IDX_WIDTH-1:0] vs1;
    logic [VEC_REG_IDX_WIDTH-1:0] vs2;
  } cntrl_req_t;

endpackage

// File: rtl/vector_lane_fu_lane_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// The first bit is produced on the start edge, so done pulses WIDTH-1 cycles after start.
module lane_divider #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor_q;

  logic [WIDTH-1:0] rem_in_c;
  logic [WIDTH-1:0] quo_in_c;
  logic [WIDTH-1:0] dsr_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] rem_next_c;
  logic [WIDTH-1:0] quo_next_c;

  // One restoring step; on start it operates directly on the incoming operands.
  always_comb begin
    rem_in_c   = running ? rem : '0;
    quo_in_c   = running ? quotient : dividend;
    dsr_c      = running ? divisor_q : divisor;
    shifted_c  = {rem_in_c, quo_in_c[WIDTH-1]};
    diff_c     = shifted_c - {1'b0, dsr_c};
    rem_next_c = diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    quo_next_c = {quo_in_c[WIDTH-2:0], ~diff_c[WIDTH]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running   <= 1'b0;
      done      <= 1'b0;
      iter      <= '0;
      rem       <= '0;
      quotient  <= '0;
      divisor_q <= '0;
    end else begin
      done <= 1'b0;
      if (running) begin
        rem      <= rem_next_c;
        quotient <= quo_next_c;
        iter     <= iter + CW'(1);
        if (iter == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end else if (start) begin
        rem       <= rem_next_c;
        quotient  <= quo_next_c;
        divisor_q <= divisor;
        iter      <= CW'(1);
        running   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_lane_fu.sv
// One vector lane: accepts a single element op, executes it (add/sub/mul/div)
// and writes the result back through a request/grant port.
module vector_lane_fu
  import vector_lane_fu_pkg::*;
#(
  parameter int unsigned VECTOR_REG_WIDTH  = vector_lane_fu_pkg::VECTOR_REG_WIDTH,
  parameter int unsigned NUM_OF_VECTOR_REG = vector_lane_fu_pkg::NUM_OF_VECTOR_REG,
  parameter int unsigned ADDR_FIELD_WIDTH  = vector_lane_fu_pkg::ADDR_FIELD_WIDTH,
  parameter int unsigned MUL_LATENCY       = vector_lane_fu_pkg::MUL_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 vld,
  input  logic [VECTOR_REG_WIDTH-1:0]          data0,
  input  logic [VECTOR_REG_WIDTH-1:0]          data1,
  input  logic [$clog2(NUM_OF_VECTOR_REG)-1:0] vec_reg_in,
  input  logic [ADDR_FIELD_WIDTH-1:0]          vec_addr,
  input  function_opcode_t                     functional_opcode,
  output logic                                 busy,
  output logic                                 wr_req_vld,
  output logic [$clog2(NUM_OF_VECTOR_REG)-1:0] wr_req_reg,
  output logic [ADDR_FIELD_WIDTH-1:0]          wr_req_addr,
  output logic [VECTOR_REG_WIDTH-1:0]          wr_req_data,
  input  logic                                 wr_req_grant,
  output logic                                 div_by_zero
);

  localparam int unsigned W   = VECTOR_REG_WIDTH;
  localparam int unsigned MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_LATENCY - 1);

  lane_state_t    state;
  lane_state_t    state_next;
  logic           accept_c;
  logic           div_start_c;
  logic           load_wb_c;
  logic [W-1:0]   result_c;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [MCW-1:0] mul_cnt;
  logic           div_done;
  logic [W-1:0]   div_quotient;

  assign accept_c    = (state == ST_IDLE) && vld;
  assign div_start_c = accept_c && (functional_opcode == SDIV);

  lane_divider #(
    .WIDTH (W)
  ) u_lane_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_c),
    .dividend (data0),
    .divisor  (data1),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the result that is captured on entry to WB.
  always_comb begin
    state_next = state;
    load_wb_c  = 1'b0;
    result_c   = '0;
    case (state)
      ST_IDLE: begin
        if (vld) begin
          case (functional_opcode)
            SMUL: state_next = ST_MUL;
            SDIV: state_next = ST_DIV;
            SSUB: begin
              state_next = ST_WB;
              load_wb_c  = 1'b1;
              result_c   = data0 - data1;
            end
            default: begin
              state_next = ST_WB;
              load_wb_c  = 1'b1;
              result_c   = data0 + data1;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_cnt == '0) begin
          state_next = ST_WB;
          load_wb_c  = 1'b1;
          result_c   = op_a * op_b;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_next = ST_WB;
          load_wb_c  = 1'b1;
          result_c   = div_quotient;
        end
      end
      ST_WB: begin
        if (wr_req_grant) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs and operand capture; destination fields only move on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      wr_req_vld  <= 1'b0;
      wr_req_reg  <= '0;
      wr_req_addr <= '0;
      wr_req_data <= '0;
      div_by_zero <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      mul_cnt     <= '0;
    end else begin
      busy        <= (state_next != ST_IDLE);
      wr_req_vld  <= (state_next == ST_WB);
      div_by_zero <= div_start_c && (data1 == '0);
      if (accept_c) begin
        op_a        <= data0;
        op_b        <= data1;
        wr_req_reg  <= vec_reg_in;
        wr_req_addr <= vec_addr;
        mul_cnt     <= MUL_LOAD;
      end else if ((state == ST_MUL) && (mul_cnt != '0)) begin
        mul_cnt <= mul_cnt - MCW'(1);
      end
      if (load_wb_c) begin
        wr_req_data <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_vector_lane_fu.sv
// Directed bench for vector_lane_fu: reset, each opcode, latency, stalls and back-to-back issue.
module tb_vector_lane_fu;
  import vector_lane_fu_pkg::*;

  logic                         clk;
  logic                         reset;
  logic                         vld;
  logic [VECTOR_REG_WIDTH-1:0]  data0;
  logic [VECTOR_REG_WIDTH-1:0]  data1;
  logic [VEC_REG_IDX_WIDTH-1:0] vec_reg_in;
  logic [ADDR_FIELD_WIDTH-1:0]  vec_addr;
  function_opcode_t             functional_opcode;
  logic                         busy;
  logic                         wr_req_vld;
  logic [VEC_REG_IDX_WIDTH-1:0] wr_req_reg;
  logic [ADDR_FIELD_WIDTH-1:0]  wr_req_addr;
  logic [VECTOR_REG_WIDTH-1:0]  wr_req_data;
  logic                         wr_req_grant;
  logic                         div_by_zero;

  int checks = 0;
  int errors = 0;

  vector_lane_fu dut (
    .clk               (clk),
    .reset             (reset),
    .vld               (vld),
    .data0             (data0),
    .data1             (data1),
    .vec_reg_in        (vec_reg_in),
    .vec_addr          (vec_addr),
    .functional_opcode (functional_opcode),
    .busy              (busy),
    .wr_req_vld        (wr_req_vld),
    .wr_req_reg        (wr_req_reg),
    .wr_req_addr       (wr_req_addr),
    .wr_req_data       (wr_req_data),
    .wr_req_grant      (wr_req_grant),
    .div_by_zero       (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation at a negedge; the following posedge is the accept edge T.
  task automatic present(input function_opcode_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] r, input logic [5:0] ad);
    @(negedge clk);
    vld = 1'b1; functional_opcode = op; data0 = a; data1 = b; vec_reg_in = r; vec_addr = ad;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; vld = 1'b0; data0 = '0; data1 = '0; vec_reg_in = '0; vec_addr = '0;
    functional_opcode = SADD; wr_req_grant = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, wr_req_vld, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {busy, wr_req_vld, div_by_zero});
    end
    checks++;
    if ({wr_req_reg, wr_req_addr, wr_req_data} !== '0) begin
      errors++; $display("FAIL reset_fields got reg=%0d addr=%0d data=%h exp 0", wr_req_reg, wr_req_addr, wr_req_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_pending();
    present(SADD, 64'd3, 64'd4, 3'd5, 6'd9);
    @(negedge clk); vld = 1'b0;
    checks++;
    if (wr_req_vld !== 1'b1 || wr_req_data !== 64'd7) begin
      errors++; $display("FAIL pend_setup got vld=%b data=%h exp vld=1 data=7", wr_req_vld, wr_req_data);
    end
    reset = 1'b1; wr_req_grant = 1'b1;
    #1;
    checks++;
    if ({busy, wr_req_vld, div_by_zero, wr_req_reg, wr_req_addr} !== '0 || wr_req_data !== '0) begin
      errors++; $display("FAIL pend_async_clear got busy=%b vld=%b data=%h exp all 0", busy, wr_req_vld, wr_req_data);
    end
    @(negedge clk); reset = 1'b0; wr_req_grant = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (wr_req_vld !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL pend_no_wb got vld=%b busy=%b exp 0 0", wr_req_vld, busy);
      end
    end
  endtask

  task automatic test_sadd();
    wr_req_grant = 1'b1;
    present(SADD, 64'd5, 64'd7, 3'd3, 6'd10);
    @(negedge clk); vld = 1'b0;
    checks++;
    if (wr_req_vld !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL sadd_vld got vld=%b busy=%b exp 1 1", wr_req_vld, busy);
    end
    checks++;
    if (wr_req_data !== 64'd12 || wr_req_reg !== 3'd3 || wr_req_addr !== 6'd10) begin
      errors++; $display("FAIL sadd_fields got data=%0d reg=%0d addr=%0d exp 12 3 10", wr_req_data, wr_req_reg, wr_req_addr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_req_vld !== 1'b0) begin
      errors++; $display("FAIL sadd_release got busy=%b vld=%b exp 0 0", busy, wr_req_vld);
    end
  endtask

  task automatic test_ssub();
    wr_req_grant = 1'b1;
    present(SSUB, 64'd0, 64'd1, 3'd1, 6'd2);
    @(negedge clk); vld = 1'b0;
    checks++;
    if (wr_req_vld !== 1'b1 || wr_req_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL ssub_wrap got vld=%b data=%h exp 1 ffffffffffffffff", wr_req_vld, wr_req_data);
    end
    @(negedge clk);
  endtask

  task automatic test_smul();
    wr_req_grant = 1'b0;
    present(SMUL, 64'h1_0000_0000, 64'h1_0000_0003, 3'd6, 6'd33);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); vld = 1'b0;
      checks++;
      if (wr_req_vld !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL smul_early k=%0d got vld=%b busy=%b exp 0 1", k, wr_req_vld, busy);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (wr_req_vld !== 1'b1 || busy !== 1'b1 || wr_req_data !== 64'h3_0000_0000 ||
          wr_req_reg !== 3'd6 || wr_req_addr !== 6'd33) begin
        errors++; $display("FAIL smul_hold k=%0d got vld=%b busy=%b data=%h exp 1 1 300000000", k, wr_req_vld, busy, wr_req_data);
      end
    end
    wr_req_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_req_vld !== 1'b0) begin
      errors++; $display("FAIL smul_release got busy=%b vld=%b exp 0 0", busy, wr_req_vld);
    end
  endtask

  // Counts cycles after accept until wr_req_vld; expects first high at T+65.
  task automatic test_sdiv(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q, input logic dbz);
    int k;
    wr_req_grant = 1'b1;
    present(SDIV, a, b, 3'd2, 6'd7);
    k = 0;
    do begin
      @(negedge clk); vld = 1'b0; k++;
      if (k <= 2) begin
        checks++;
        if (div_by_zero !== (dbz && k == 1)) begin
          errors++; $display("FAIL sdiv_dbz k=%0d got %b exp %b", k, div_by_zero, dbz && k == 1);
        end
      end
    end while (wr_req_vld !== 1'b1 && k < 200);
    checks++;
    if (k != 65) begin
      errors++; $display("FAIL sdiv_latency got T+%0d exp T+65", k);
    end
    checks++;
    if (wr_req_data !== q) begin
      errors++; $display("FAIL sdiv_quotient got %h exp %h", wr_req_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    wr_req_grant = 1'b1;
    present(SDIV, 64'd1000, 64'd3, 3'd4, 6'd4);
    repeat (30) begin
      @(negedge clk); vld = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || wr_req_vld !== 1'b0) begin
      errors++; $display("FAIL middiv_reset got busy=%b vld=%b exp 0 0", busy, wr_req_vld);
    end
    @(negedge clk); reset = 1'b0;
    present(SADD, 64'd1, 64'd1, 3'd0, 6'd0);
    @(negedge clk); vld = 1'b0;
    checks++;
    if (wr_req_vld !== 1'b1 || wr_req_data !== 64'd2) begin
      errors++; $display("FAIL middiv_sadd got vld=%b data=%0d exp 1 2", wr_req_vld, wr_req_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    wr_req_grant = 1'b1;
    present(SADD, 64'd1, 64'd2, 3'd1, 6'd1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wr_req_vld !== 1'b1 || wr_req_data !== 64'd3) begin
      errors++; $display("FAIL b2b_first got busy=%b vld=%b data=%0d exp 1 1 3", busy, wr_req_vld, wr_req_data);
    end
    data0 = 64'd10; data1 = 64'd20; vec_reg_in = 3'd2; vec_addr = 6'd20;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_req_vld !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got busy=%b vld=%b exp 0 0", busy, wr_req_vld);
    end
    @(negedge clk); vld = 1'b0;
    checks++;
    if (wr_req_vld !== 1'b1 || wr_req_data !== 64'd30 || wr_req_reg !== 3'd2 || wr_req_addr !== 6'd20) begin
      errors++; $display("FAIL b2b_second got vld=%b data=%0d reg=%0d addr=%0d exp 1 30 2 20", wr_req_vld, wr_req_data, wr_req_reg, wr_req_addr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_pending();
    test_sadd();
    test_ssub();
    test_smul();
    test_sdiv(64'd100, 64'd7, 64'd14, 1'b0);
    test_sdiv(64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    test_reset_mid_div();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
